// File: rtl/intr_gateway_arb.sv
// intr_gateway_arb: interrupt gateway and round-robin request arbiter.
// Each source latches a trigger as pending, is offered to the interrupt controller
// over a registered valid/ready handshake, and stays blocked until it is completed.
// Optional build macro GATEWAY_EDGE_COUNT_EN: count rising edges per source
// (saturating CNT_W-bit counter) instead of sampling the level directly.
module intr_gateway_arb #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] io_irq,
    output logic               io_req_valid,
    input  logic               io_req_ready,
    output logic [ID_W-1:0]    io_req_id,
    input  logic               io_complete_valid,
    input  logic [ID_W-1:0]    io_complete_id,
    output logic [NUM_SRC-1:0] io_inflight
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SERV = 2'd2
    } src_state_e;

    logic               req_valid_q, req_valid_d;
    logic [ID_W-1:0]    req_id_q, req_id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               fire;
    logic [NUM_SRC-1:0] cand;

    assign io_req_valid = req_valid_q;
    assign io_req_id    = req_id_q;
    assign fire         = req_valid_q && io_req_ready;

    // First set bit of cand at or after ptr, wrapping; {found, id}.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_SRC-1:0] c,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            idx = int'(ptr) + j;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!res[ID_W] && c[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    // Per-source gateway: trigger detection, IDLE/PEND/SERV state machine.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        src_state_e state_q, state_d;
        logic       trig;
        logic       granted;
        logic       completed;

        assign granted   = fire && (req_id_q == ID_W'(gi));
        assign completed = io_complete_valid && (io_complete_id == ID_W'(gi));

`ifdef GATEWAY_EDGE_COUNT_EN
        logic             prev_irq_q, prev_irq_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             rise;

        assign rise = io_irq[gi] & ~prev_irq_q;
        assign trig = (cnt_q != '0);

        // Outstanding-edge counter: saturating increment, decrement on grant.
        always_comb begin
            prev_irq_d = io_irq[gi];
            cnt_d      = cnt_q;
            if (rise && granted) begin
                cnt_d = cnt_q;
            end else if (rise) begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (granted && (cnt_q != '0)) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // Edge-detect and counter registers.
        always_ff @(posedge clock) begin
            if (reset) begin
                prev_irq_q <= 1'b0;
                cnt_q      <= '0;
            end else begin
                prev_irq_q <= prev_irq_d;
                cnt_q      <= cnt_d;
            end
        end
`else
        assign trig = io_irq[gi];
`endif

        // Next-state logic: latch trigger, move to service on grant, release on complete.
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE: if (trig)      state_d = ST_PEND;
                ST_PEND: if (granted)   state_d = ST_SERV;
                ST_SERV: if (completed) state_d = ST_IDLE;
                default:                state_d = ST_IDLE;
            endcase
        end

        // Source state register.
        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // The source being granted this cycle must not be re-offered.
        assign cand[gi]        = (state_q == ST_PEND) && !granted;
        assign io_inflight[gi] = (state_q == ST_SERV);
    end

    // Arbitration: reload the offer when empty or consumed, pointer advances past the grant.
    always_comb begin
        logic [ID_W:0] pick;
        req_valid_d = req_valid_q;
        req_id_d    = req_id_q;
        ptr_d       = ptr_q;
        if (fire) begin
            ptr_d = (int'(req_id_q) == NUM_SRC - 1) ? '0 : req_id_q + 1'b1;
        end
        pick = rr_pick(cand, ptr_d);
        if (!req_valid_q || fire) begin
            req_valid_d = pick[ID_W];
            req_id_d    = pick[ID_W] ? pick[ID_W-1:0] : '0;
        end
    end

    // Offer and round-robin pointer registers; reset drops any pending offer.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_valid_q <= 1'b0;
            req_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            req_id_q    <= req_id_d;
            ptr_q       <= ptr_d;
        end
    end

endmodule
